// File: rtl/logic_sweep_ctrl_if.sv
// Bus between the truth-table sweep sequencer and its surroundings.
// The slave side is the sequencer; the master side issues jobs, supplies the
// F output of the function under test, and observes progress and results.
interface logic_sweep_ctrl_if;
  logic        start;
  logic        abort;
  logic        nvars;
  logic [15:0] golden;
  logic        f_in;
  logic [3:0]  vec_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  err_count;
  logic [15:0] result_tt;

  modport master (
    output start, abort, nvars, golden, f_in,
    input  vec_out, busy, done, pass, err_count, result_tt
  );

  modport slave (
    input  start, abort, nvars, golden, f_in,
    output vec_out, busy, done, pass, err_count, result_tt
  );
endinterface

// File: rtl/logic_sweep_ctrl.sv
// logic_sweep_ctrl: walks a 3- or 4-input combinational block through every
// input vector, waits HOLD settle cycles per vector, samples F and compares it
// against a golden truth table. Reports the captured table, mismatch count
// and pass/fail.
// Optional feature macro: SWEEP_STOP_ON_ERR_EN -- when defined, the first
// mismatching sample ends the sweep immediately.
module logic_sweep_ctrl #(
  parameter int HOLD = 2
) (
  input logic               clk,
  input logic               rst_n,
  logic_sweep_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [3:0]  r_idx;
  logic [7:0]  r_hold;
  logic        r_nvars;
  logic [15:0] r_golden;
  logic [4:0]  r_err;
  logic [15:0] r_tt;
  logic        r_pass;

  logic        w_last;
  logic        w_mis;
  logic        w_hold_end;
  logic        w_stop_en;
  logic        w_end;

`ifdef SWEEP_STOP_ON_ERR_EN
  assign w_stop_en = 1'b1;
`else
  assign w_stop_en = 1'b0;
`endif

  assign w_last     = r_nvars ? (r_idx == 4'd15) : (r_idx == 4'd7);
  assign w_mis      = (bus.f_in != r_golden[r_idx]);
  assign w_hold_end = (r_hold == 8'(HOLD - 1));
  // The sweep ends on the last vector, or on the first mismatch in stop mode
  assign w_end      = w_last || (w_stop_en && w_mis);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; abort overrides everything, including a start in IDLE
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (bus.start) w_next = S_APPLY;
      S_APPLY:  if (w_hold_end) w_next = S_SAMPLE;
      S_SAMPLE: w_next = w_end ? S_DONE : S_APPLY;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (bus.abort) w_next = S_IDLE;
  end

  // Datapath: latch the job on accept, walk vectors, capture F, tally mismatches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_hold   <= '0;
      r_nvars  <= 1'b0;
      r_golden <= '0;
      r_err    <= '0;
      r_tt     <= '0;
      r_pass   <= 1'b0;
    end else if (bus.abort) begin
      // Partial table and count stay visible; an aborted sweep never passes
      r_pass <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_nvars  <= bus.nvars;
            r_golden <= bus.golden;
            r_err    <= '0;
            r_tt     <= '0;
            r_pass   <= 1'b0;
            r_idx    <= '0;
            r_hold   <= '0;
          end
        end
        S_APPLY: begin
          r_hold <= w_hold_end ? 8'd0 : r_hold + 8'd1;
        end
        S_SAMPLE: begin
          r_tt[r_idx] <= bus.f_in;
          if (w_mis) r_err <= r_err + 5'd1;
          // idx stays on the final vector so vec_out keeps it through IDLE
          if (!w_end) r_idx <= r_idx + 4'd1;
        end
        S_DONE: begin
          r_pass <= (r_err == 5'd0);
        end
        default: ;
      endcase
    end
  end

  // 3-input functions see {0,A,B,C}; 4-input functions see {A,B,C,D}
  assign bus.vec_out   = r_nvars ? r_idx : {1'b0, r_idx[2:0]};
  assign bus.busy      = (r_state == S_APPLY) || (r_state == S_SAMPLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.pass      = r_pass;
  assign bus.err_count = r_err;
  assign bus.result_tt = r_tt;

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
// Bench for logic_sweep_ctrl: two instances (HOLD=1 and HOLD=2) share clock
// and reset; sel chooses which one the directed steps drive and observe.
// Expected vectors are queued when a sweep is launched and popped as each
// vector appears on vec_out.
module tb_logic_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        sel = 1'b0;
  logic        t_start = 1'b0;
  logic        t_abort = 1'b0;
  logic        t_nvars = 1'b0;
  logic [15:0] t_golden = '0;
  int          fmode = 0;

  int total = 0;
  int bad = 0;

  logic [3:0] vq[$];

  logic_sweep_ctrl_if b1 ();
  logic_sweep_ctrl_if b2 ();

  logic_sweep_ctrl #(.HOLD(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  logic_sweep_ctrl #(.HOLD(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  always #5 clk = ~clk;

  // Function under test: 0 -> Y = ~B (B = vec_out[1]), 1 -> even parity, 2 -> stuck 0
  function automatic logic fmodel(input int m, input logic [3:0] v);
    case (m)
      0:       return ~v[1];
      1:       return ~(^v);
      default: return 1'b0;
    endcase
  endfunction

  assign b1.start  = t_start & ~sel;
  assign b2.start  = t_start & sel;
  assign b1.abort  = t_abort & ~sel;
  assign b2.abort  = t_abort & sel;
  assign b1.nvars  = t_nvars;
  assign b2.nvars  = t_nvars;
  assign b1.golden = t_golden;
  assign b2.golden = t_golden;
  assign b1.f_in   = fmodel(fmode, b1.vec_out);
  assign b2.f_in   = fmodel(fmode, b2.vec_out);

  logic [3:0]  m_vec;
  logic        m_busy, m_done, m_pass;
  logic [4:0]  m_err;
  logic [15:0] m_tt;
  assign m_vec  = sel ? b2.vec_out   : b1.vec_out;
  assign m_busy = sel ? b2.busy      : b1.busy;
  assign m_done = sel ? b2.done      : b1.done;
  assign m_pass = sel ? b2.pass      : b1.pass;
  assign m_err  = sel ? b2.err_count : b1.err_count;
  assign m_tt   = sel ? b2.result_tt : b1.result_tt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch a sweep at the current negedge and follow it to the cycle after done
  task automatic run_sweep(input string tag, input logic s, input logic nv,
                           input logic [15:0] g, input int fm, input int hold,
                           input int nvec, input logic [15:0] ett,
                           input int eerr, input logic epass);
    logic [3:0] v;
    v = '0;
    sel = s; t_nvars = nv; t_golden = g; fmode = fm;
    for (int i = 0; i < nvec; i++) vq.push_back(nv ? 4'(i) : {1'b0, 3'(i)});
    t_start = 1'b1;
    @(negedge clk);
    t_start = 1'b0;
    chk({tag, ".clr_err"}, 32'(m_err), 32'd0);
    chk({tag, ".clr_tt"},  32'(m_tt),  32'd0);
    for (int i = 0; i < nvec; i++) begin
      v = vq.pop_front();
      chk($sformatf("%s.vec%0d", tag, i),  32'(m_vec),  32'(v));
      chk($sformatf("%s.busy%0d", tag, i), 32'(m_busy), 32'd1);
      chk($sformatf("%s.done%0d", tag, i), 32'(m_done), 32'd0);
      repeat (hold + 1) @(negedge clk);
    end
    chk({tag, ".done"},     32'(m_done), 32'd1);
    chk({tag, ".busy_off"}, 32'(m_busy), 32'd0);
    chk({tag, ".tt"},       32'(m_tt),   32'(ett));
    chk({tag, ".err"},      32'(m_err),  32'(eerr));
    chk({tag, ".vec_hold"}, 32'(m_vec),  32'(v));
    @(negedge clk);
    chk({tag, ".done_pulse"}, 32'(m_done), 32'd0);
    chk({tag, ".pass"},       32'(m_pass), 32'(epass));
  endtask

  initial begin
    int seen;

    // Reset state of both instances
    repeat (2) @(negedge clk);
    sel = 1'b1;
    chk("rst.vec",  32'(m_vec),  32'd0);
    chk("rst.busy", 32'(m_busy), 32'd0);
    chk("rst.done", 32'(m_done), 32'd0);
    chk("rst.pass", 32'(m_pass), 32'd0);
    chk("rst.err",  32'(m_err),  32'd0);
    chk("rst.tt",   32'(m_tt),   32'd0);
    chk("rst.dut1", {b1.vec_out, b1.busy, b1.done, b1.pass, b1.err_count, b1.result_tt}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle.busy", 32'(m_busy), 32'd0);

    // HOLD=1, 3-input, Y = ~B: done 16 cycles after the start edge
    run_sweep("h1notb", 1'b0, 1'b0, 16'h0033, 0, 1, 8, 16'h0033, 0, 1'b1);

    // HOLD=2, 4-input, F stuck at 0 against the parity table
`ifdef SWEEP_STOP_ON_ERR_EN
    run_sweep("stuck", 1'b1, 1'b1, 16'h9669, 2, 2, 1, 16'h0000, 1, 1'b0);
`else
    run_sweep("stuck", 1'b1, 1'b1, 16'h9669, 2, 2, 16, 16'h0000, 8, 1'b0);
`endif

    // Back-to-back: start in the cycle after done, parity function, 48 cycles
    run_sweep("parity", 1'b1, 1'b1, 16'h9669, 1, 2, 16, 16'h9669, 0, 1'b1);

    // Start pulses while busy are ignored; abort at vector 3
    sel = 1'b1; t_nvars = 1'b1; t_golden = 16'h9669; fmode = 1;
    t_start = 1'b1;
    @(negedge clk);
    t_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort.vec1", 32'(m_vec), 32'd1);
    t_start = 1'b1;
    @(negedge clk);
    t_start = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort.vec3", 32'(m_vec),  32'd3);
    chk("abort.busy", 32'(m_busy), 32'd1);
    t_abort = 1'b1;
    @(negedge clk);
    t_abort = 1'b0;
    chk("abort.idle", 32'(m_busy), 32'd0);
    chk("abort.done", 32'(m_done), 32'd0);
    chk("abort.pass", 32'(m_pass), 32'd0);
    chk("abort.tt",   32'(m_tt),   32'h0001);
    chk("abort.err",  32'(m_err),  32'd0);
    chk("abort.vec",  32'(m_vec),  32'd3);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_done || m_busy) seen++;
    end
    chk("abort.quiet", 32'(seen), 32'd0);

    // start and abort together in IDLE: abort wins
    t_start = 1'b1; t_abort = 1'b1;
    @(negedge clk);
    t_start = 1'b0; t_abort = 1'b0;
    chk("abort_wins.busy", 32'(m_busy), 32'd0);
    chk("abort_wins.tt",   32'(m_tt),   32'h0001);

    // Asynchronous reset during vector 5 APPLY
    t_start = 1'b1;
    @(negedge clk);
    t_start = 1'b0;
    repeat (15) @(negedge clk);
    chk("rstmid.vec5", 32'(m_vec), 32'd5);
    chk("rstmid.tt_pre", 32'(m_tt), 32'h0009);
    rst_n = 1'b0;
    #1;
    chk("rstmid.vec",  32'(m_vec),  32'd0);
    chk("rstmid.busy", 32'(m_busy), 32'd0);
    chk("rstmid.done", 32'(m_done), 32'd0);
    chk("rstmid.pass", 32'(m_pass), 32'd0);
    chk("rstmid.err",  32'(m_err),  32'd0);
    chk("rstmid.tt",   32'(m_tt),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (m_done || m_busy) seen++;
    end
    chk("rstmid.quiet", 32'(seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logic_sweep_ctrl.md
# logic_sweep_ctrl

Sequencer that exhaustively drives a lab combinational function block (3- or 4-input, single output F) through every input combination and samples F after a programmable settle time. It compares each sample against a golden truth table and reports the captured table, a mismatch count and pass/fail. It sits between the lab's switch/LED top level and any gates-level or operator-level function module, replacing manual truth-table checking on the board.

## Interface
- HOLD, default 2: settle cycles per vector before sampling (1..255).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin sweep; accepted only in IDLE.
- abort  in  1  synchronous; returns to IDLE from any state without asserting done.
- nvars  in  1  0 = 3-input function (8 vectors), 1 = 4-input (16 vectors); latched at start.
- golden  in  16  expected F per vector index; bit i = vector i; latched at start; bits 15:8 ignored when nvars=0.
- f_in  in  1  F output of the function under test.
- vec_out  out  4  drives {inA,inB,inC,inD}: 4-input = {A,B,C,D} = index; 3-input = {0,A,B,C} = {0,index[2:0]}.
- busy  out  1  high in APPLY/SAMPLE.
- done  out  1  one-cycle pulse at sweep end.
- pass  out  1  err_count==0 at last completed sweep.
- err_count  out  5  mismatches in last/current sweep (0..16).
- result_tt  out  16  captured F per vector index.

## Operation
- States: IDLE, APPLY, SAMPLE, DONE.
- IDLE: start=1 -> latch nvars/golden, clear err_count, result_tt, pass; idx=0; hold counter=0; go APPLY.
- APPLY: vec_out = mapped idx; count HOLD cycles; on HOLD-th cycle go SAMPLE.
- SAMPLE: vec_out unchanged; result_tt[idx] <= f_in; if f_in != golden[idx], err_count += 1. If idx == last (7 or 15) -> DONE, else idx += 1, -> APPLY.
- DONE: done=1 for one cycle; pass <= (final err_count==0); -> IDLE.
- IDLE outputs: vec_out holds last applied vector; result_tt, err_count, pass hold until next start.
- start while not IDLE: ignored. start and abort together in IDLE: abort wins, stays IDLE.
- abort: -> IDLE next edge; result_tt/err_count retain partial values; pass = 0; no done pulse.
- Unused result_tt bits (15:8 when nvars=0) remain 0.
- Counter widths: idx 4 bits; hold counter 8 bits; err_count saturates cannot occur (max 16 fits).

## Timing
- Reset (async, any state): state=IDLE, vec_out=0, busy=0, done=0, pass=0, err_count=0, result_tt=0.
- start sampled high at edge k -> busy and vec_out=vector 0 valid after edge k.
- Each vector occupies HOLD+1 cycles (HOLD APPLY + 1 SAMPLE); f_in sampled on the edge ending SAMPLE.
- done asserted in the cycle after the last SAMPLE edge; start-to-done = N*(HOLD+1) cycles after edge k (N = 8 or 16); busy low during done.
- err_count/result_tt update on each SAMPLE edge (visible live during sweep).
- New start accepted the cycle after done (IDLE).

## Configuration
- SWEEP_STOP_ON_ERR_EN defined: first mismatch ends the sweep at that SAMPLE edge -> DONE (done pulse, pass=0, err_count=1, remaining result_tt bits 0).
- Undefined: sweep always covers all N vectors; err_count counts all mismatches.

## Test plan
- Reset mid-sweep: assert rst_n=0 during vector 5 APPLY -> all outputs 0 immediately, IDLE, no done.
- HOLD=1, nvars=0, golden=0x0033, f_in model Y=~B (B=vec_out[1]) -> vec_out 0..7, done 16 cycles after start edge, result_tt=0x0033, err_count=0, pass=1.
- HOLD=2, nvars=1, golden=0x9669, f_in model even parity of vec_out -> result_tt=0x9669, pass=1, done 48 cycles after start.
- Same as above with f_in stuck 0 -> result_tt=0x0000, err_count=8, pass=0 (macro undefined); with SWEEP_STOP_ON_ERR_EN -> done after vector 0, err_count=1.
- start pulses during busy and abort at vector 3 -> start ignored; abort returns IDLE next edge, no done, pass=0, result_tt holds bits 0..2.
- Back-to-back: start in cycle after done -> new sweep begins, err_count/result_tt cleared on accept.
